uart_cmd_decoder: RTL and testbench

Byte-to-command framer sitting directly downstream of `uart_rx`: consumes each received byte (`readdata`/`done` pulse) and assembles fixed-format frames into single bus commands for the bus master. Supports a 3-byte write frame and a 2-byte read frame, enforces an inter-byte gap timeout, and holds each decoded command on a valid/ready handshake until the bus side accepts it.

---
 rtl/uart_cmd_pkg.sv | 17 +
 rtl/gap_timer.sv | 31 +++
 rtl/uart_cmd_decoder.sv | 136 +++++++++++++
 tb/tb_uart_cmd_decoder.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared constants for the UART command decoder: command opcodes, FSM state
// codes and default gap-timeout sizing for 9600 baud on a 50 MHz clock.
package uart_cmd_pkg;

   localparam logic [7:0] CMD_WRITE = 8'h57;
   localparam logic [7:0] CMD_READ  = 8'h52;

   // Two 10-bit characters at 9600 baud, 50 MHz clock
   localparam int DEFAULT_TIMEOUT_CYCLES = 104160;
   localparam int DEFAULT_CNT_W          = 17;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ADDR  = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_VALID = 2'd3;

endpackage

// File: rtl/gap_timer.sv
// Inter-byte gap counter: counts enabled cycles since the last clear and
// flags when the count has reached TIMEOUT_CYCLES.
module gap_timer
   import uart_cmd_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
   parameter int CNT_W          = DEFAULT_CNT_W
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   logic [CNT_W-1:0] count;

   // Counting stops at the limit so the count never wraps back to a safe value
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && !expired) begin
         count <= count + CNT_W'(1);
      end
   end

   assign expired = (count == CNT_W'(TIMEOUT_CYCLES));

endmodule

// File: rtl/uart_cmd_decoder.sv
// Assembles bytes from uart_rx into write (57 addr data) or read (52 addr)
// commands and holds each one on a valid/ready handshake until accepted.
module uart_cmd_decoder
   import uart_cmd_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
   parameter int CNT_W          = DEFAULT_CNT_W
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] rx_data,
   input  logic       rx_done,
   output logic       cmd_valid,
   input  logic       cmd_ready,
   output logic       cmd_write,
   output logic [7:0] cmd_addr,
   output logic [7:0] cmd_wdata,
   output logic       err_cmd,
   output logic       err_timeout,
   output logic       err_overrun
);

   logic [1:0] state;
   logic [1:0] state_nxt;
   logic       write_nxt;
   logic [7:0] addr_nxt;
   logic [7:0] wdata_nxt;
   logic       err_cmd_nxt;
   logic       err_timeout_nxt;
   logic       err_overrun_nxt;
   logic       take_cmd;
   logic       in_frame;
   logic       expired;

   assign in_frame = (state == ST_ADDR) || (state == ST_DATA);

   gap_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .CNT_W          (CNT_W)
   ) u_gap_timer (
      .clock   (clock),
      .reset   (reset),
      .clear   (rx_done || !in_frame),
      .enable  (in_frame),
      .expired (expired)
   );

   // A byte that completes a handshake in VALID is treated as a fresh opcode,
   // so the opcode decode is shared between IDLE and that case via take_cmd.
   always_comb begin
      state_nxt       = state;
      write_nxt       = cmd_write;
      addr_nxt        = cmd_addr;
      wdata_nxt       = cmd_wdata;
      err_cmd_nxt     = 1'b0;
      err_timeout_nxt = 1'b0;
      err_overrun_nxt = 1'b0;
      take_cmd        = 1'b0;

      case (state)
         ST_IDLE: begin
            take_cmd = rx_done;
         end
         ST_ADDR: begin
            if (rx_done) begin
               addr_nxt = rx_data;
               if (cmd_write) begin
                  state_nxt = ST_DATA;
               end else begin
                  wdata_nxt = 8'h00;
                  state_nxt = ST_VALID;
               end
            end else if (expired) begin
               err_timeout_nxt = 1'b1;
               state_nxt       = ST_IDLE;
            end
         end
         ST_DATA: begin
            if (rx_done) begin
               wdata_nxt = rx_data;
               state_nxt = ST_VALID;
            end else if (expired) begin
               err_timeout_nxt = 1'b1;
               state_nxt       = ST_IDLE;
            end
         end
         ST_VALID: begin
            if (cmd_ready) begin
               state_nxt = ST_IDLE;
               take_cmd  = rx_done;
            end else if (rx_done) begin
               err_overrun_nxt = 1'b1;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase

      if (take_cmd) begin
         if (rx_data == CMD_WRITE) begin
            state_nxt = ST_ADDR;
            write_nxt = 1'b1;
         end else if (rx_data == CMD_READ) begin
            state_nxt = ST_ADDR;
            write_nxt = 1'b0;
         end else begin
            err_cmd_nxt = 1'b1;
         end
      end
   end

   // Every output is a flop so the bus side sees glitch-free values
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         cmd_valid   <= 1'b0;
         cmd_write   <= 1'b0;
         cmd_addr    <= 8'h00;
         cmd_wdata   <= 8'h00;
         err_cmd     <= 1'b0;
         err_timeout <= 1'b0;
         err_overrun <= 1'b0;
      end else begin
         state       <= state_nxt;
         cmd_valid   <= (state_nxt == ST_VALID);
         cmd_write   <= write_nxt;
         cmd_addr    <= addr_nxt;
         cmd_wdata   <= wdata_nxt;
         err_cmd     <= err_cmd_nxt;
         err_timeout <= err_timeout_nxt;
         err_overrun <= err_overrun_nxt;
      end
   end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Self-checking bench for uart_cmd_decoder: directed frames plus random byte
// streams compared cycle by cycle against a byte-queue model of the framer.
module tb_uart_cmd_decoder;

   localparam int TIMEOUT = 100;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       rx_done = 1'b0;
   logic       cmd_ready = 1'b0;
   logic       cmd_valid;
   logic       cmd_write;
   logic [7:0] cmd_addr;
   logic [7:0] cmd_wdata;
   logic       err_cmd;
   logic       err_timeout;
   logic       err_overrun;

   int checks = 0;
   int failures = 0;

   logic [7:0] frame_q[$];
   int         gap;
   bit         m_pending;
   bit         m_write;
   logic [7:0] m_addr;
   logic [7:0] m_wdata;
   bit         e_cmd;
   bit         e_timeout;
   bit         e_overrun;

   uart_cmd_decoder #(
      .TIMEOUT_CYCLES (TIMEOUT),
      .CNT_W          (7)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .rx_data     (rx_data),
      .rx_done     (rx_done),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_write   (cmd_write),
      .cmd_addr    (cmd_addr),
      .cmd_wdata   (cmd_wdata),
      .err_cmd     (err_cmd),
      .err_timeout (err_timeout),
      .err_overrun (err_overrun)
   );

   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   function automatic void modelReset();
      frame_q.delete();
      gap       = 0;
      m_pending = 1'b0;
      m_write   = 1'b0;
      m_addr    = 8'h00;
      m_wdata   = 8'h00;
      e_cmd     = 1'b0;
      e_timeout = 1'b0;
      e_overrun = 1'b0;
   endfunction

   // Model: a pending command, a queue of bytes of the frame being built, and
   // a count of byte-free cycles since the last byte of that frame.
   function automatic void modelStep(input bit done, input logic [7:0] b, input bit ready);
      e_cmd     = 1'b0;
      e_timeout = 1'b0;
      e_overrun = 1'b0;
      if (m_pending) begin
         if (ready) begin
            m_pending = 1'b0;
         end else if (done) begin
            e_overrun = 1'b1;
            done      = 1'b0;
         end
      end
      if (done) begin
         if (frame_q.size() == 0 && b != 8'h57 && b != 8'h52) begin
            e_cmd = 1'b1;
         end else begin
            frame_q.push_back(b);
            gap = 0;
            if (frame_q[0] == 8'h57 && frame_q.size() == 3) begin
               m_pending = 1'b1;
               m_write   = 1'b1;
               m_addr    = frame_q[1];
               m_wdata   = frame_q[2];
               frame_q.delete();
            end else if (frame_q[0] == 8'h52 && frame_q.size() == 2) begin
               m_pending = 1'b1;
               m_write   = 1'b0;
               m_addr    = frame_q[1];
               m_wdata   = 8'h00;
               frame_q.delete();
            end
         end
      end else if (frame_q.size() > 0) begin
         gap++;
         if (gap > TIMEOUT) begin
            e_timeout = 1'b1;
            frame_q.delete();
         end
      end
   endfunction

   task automatic compareAll();
      checkOutput("cmd_valid", 32'(cmd_valid), 32'(m_pending));
      checkOutput("err_cmd", 32'(err_cmd), 32'(e_cmd));
      checkOutput("err_timeout", 32'(err_timeout), 32'(e_timeout));
      checkOutput("err_overrun", 32'(err_overrun), 32'(e_overrun));
      if (m_pending) begin
         checkOutput("cmd_write", 32'(cmd_write), 32'(m_write));
         checkOutput("cmd_addr", 32'(cmd_addr), 32'(m_addr));
         checkOutput("cmd_wdata", 32'(cmd_wdata), 32'(m_wdata));
      end
   endtask

   // One clock: drive inputs, let the edge happen, advance the model, compare
   task automatic applyStimulus(input logic done, input logic [7:0] data, input logic ready);
      rx_done   = done;
      rx_data   = data;
      cmd_ready = ready;
      @(posedge clock);
      #1;
      modelStep(done, data, ready);
      compareAll();
      rx_done = 1'b0;
   endtask

   task automatic sendByte(input logic [7:0] b, input logic ready);
      applyStimulus(1'b1, b, ready);
   endtask

   task automatic idleCycles(input int n, input logic ready);
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'b0, 8'($urandom_range(0, 255)), ready);
      end
   endtask

   task automatic applyReset();
      rx_done = 1'b0;
      reset   = 1'b1;
      #2;
      modelReset();
      compareAll();
      checkOutput("rst_cmd_write", 32'(cmd_write), 32'h0);
      checkOutput("rst_cmd_addr", 32'(cmd_addr), 32'h0);
      checkOutput("rst_cmd_wdata", 32'(cmd_wdata), 32'h0);
      @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   function automatic logic [7:0] pickByte();
      int unsigned r;
      r = $urandom_range(0, 9);
      if (r < 4) return 8'h57;
      if (r < 7) return 8'h52;
      return 8'($urandom_range(0, 255));
   endfunction

   initial begin
      reset = 1'b1;
      @(posedge clock);
      #1;
      applyReset();

      $display("[TB] write frame 57 10 AB");
      sendByte(8'h57, 1'b1);
      sendByte(8'h10, 1'b1);
      sendByte(8'hAB, 1'b1);
      checkOutput("wr_valid", 32'(cmd_valid), 32'h1);
      checkOutput("wr_addr", 32'(cmd_addr), 32'h10);
      checkOutput("wr_wdata", 32'(cmd_wdata), 32'hAB);
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("wr_valid_drop", 32'(cmd_valid), 32'h0);

      $display("[TB] read frame 52 3C held 20 cycles");
      sendByte(8'h52, 1'b0);
      sendByte(8'h3C, 1'b0);
      idleCycles(20, 1'b0);
      checkOutput("rd_write", 32'(cmd_write), 32'h0);
      checkOutput("rd_addr", 32'(cmd_addr), 32'h3C);
      checkOutput("rd_wdata", 32'(cmd_wdata), 32'h00);
      applyStimulus(1'b0, 8'h00, 1'b1);
      idleCycles(2, 1'b1);

      $display("[TB] unknown opcode FF then read 52 01");
      sendByte(8'hFF, 1'b0);
      checkOutput("bad_opcode_pulse", 32'(err_cmd), 32'h1);
      idleCycles(1, 1'b0);
      sendByte(8'h52, 1'b0);
      sendByte(8'h01, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b1);

      $display("[TB] gap timeout and exact-limit byte");
      sendByte(8'h57, 1'b0);
      sendByte(8'h20, 1'b0);
      idleCycles(TIMEOUT + 1, 1'b0);
      checkOutput("timeout_pulse", 32'(err_timeout), 32'h1);
      idleCycles(2, 1'b0);
      sendByte(8'h57, 1'b0);
      sendByte(8'h20, 1'b0);
      sendByte(8'h55, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b1);
      sendByte(8'h57, 1'b0);
      idleCycles(TIMEOUT, 1'b0);
      sendByte(8'h20, 1'b0);
      idleCycles(TIMEOUT, 1'b0);
      sendByte(8'h55, 1'b0);
      checkOutput("limit_valid", 32'(cmd_valid), 32'h1);
      checkOutput("limit_wdata", 32'(cmd_wdata), 32'h55);
      checkOutput("limit_no_timeout", 32'(err_timeout), 32'h0);
      applyStimulus(1'b0, 8'h00, 1'b1);

      $display("[TB] overrun and coincident handshake");
      sendByte(8'h52, 1'b0);
      sendByte(8'h44, 1'b0);
      sendByte(8'h57, 1'b0);
      checkOutput("overrun_pulse", 32'(err_overrun), 32'h1);
      checkOutput("overrun_addr_kept", 32'(cmd_addr), 32'h44);
      sendByte(8'h57, 1'b1);
      checkOutput("coincident_no_overrun", 32'(err_overrun), 32'h0);
      sendByte(8'h10, 1'b0);
      sendByte(8'hAB, 1'b0);
      checkOutput("coincident_addr", 32'(cmd_addr), 32'h10);
      applyStimulus(1'b0, 8'h00, 1'b1);

      $display("[TB] reset mid-frame and mid-valid");
      sendByte(8'h57, 1'b0);
      sendByte(8'h10, 1'b0);
      applyReset();
      sendByte(8'h10, 1'b0);
      checkOutput("post_reset_err_cmd", 32'(err_cmd), 32'h1);
      sendByte(8'hAB, 1'b0);
      idleCycles(3, 1'b0);
      sendByte(8'h52, 1'b0);
      sendByte(8'h77, 1'b0);
      applyReset();
      idleCycles(3, 1'b1);

      $display("[TB] random stream");
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 149) == 0) begin
            idleCycles(int'($urandom_range(TIMEOUT - 4, TIMEOUT + 4)), 1'($urandom_range(0, 1)));
         end else begin
            applyStimulus(1'($urandom_range(0, 2) == 0), pickByte(), 1'($urandom_range(0, 3) != 0));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
